traffic_light_monitor: RTL and testbench

//  Passive checker on a traffic-light controller's red/green lamp outputs. Decodes the

---
 rtl/traffic_mon_pkg.sv | 30 +++
 rtl/traffic_light_monitor_dwell_counter.sv | 20 ++
 rtl/traffic_light_monitor.sv | 149 ++++++++++++++
 tb/tb_traffic_light_monitor.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_mon_pkg.sv
// Shared encodings for the traffic-light monitor: phases, FSM states and lamp-pair decode.
package traffic_mon_pkg;

  typedef enum logic [1:0] {
    PH_UNKNOWN = 2'd0,
    PH_RED     = 2'd1,
    PH_GREEN   = 2'd2
  } phase_e;

  typedef enum logic [1:0] {
    SYNC     = 2'd0,
    IN_RED   = 2'd1,
    IN_GREEN = 2'd2
  } state_e;

  // {red, green} as sampled from the controller
  localparam logic [1:0] LAMP_DARK  = 2'b00;
  localparam logic [1:0] LAMP_GREEN = 2'b01;
  localparam logic [1:0] LAMP_RED   = 2'b10;
  localparam logic [1:0] LAMP_BOTH  = 2'b11;

  function automatic phase_e phase_of(input state_e s);
    case (s)
      IN_RED:   return PH_RED;
      IN_GREEN: return PH_GREEN;
      default:  return PH_UNKNOWN;
    endcase
  endfunction

endpackage

// File: rtl/traffic_light_monitor_dwell_counter.sv
// Saturating dwell counter: clear beats load-to-1, load beats increment.
module dwell_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load1,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   count <= '0;
    else if (clr)                count <= '0;
    else if (load1)              count <= CNT_W'(1);
    else if (inc && count != '1) count <= count + CNT_W'(1);
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive red/green lamp checker: phase decode, alternation, dwell limits, sticky errors.
// Optional MON_DWELL_STATS_EN adds last_dwell / peak_dwell outputs.
module traffic_light_monitor
  import traffic_mon_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int RED_MIN = 1,
  parameter int RED_MAX = 2,
  parameter int GRN_MIN = 1,
  parameter int GRN_MAX = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             red,
  input  logic             green,
  input  logic             clr_err,
  output logic [1:0]       phase,
  output logic             synced,
  output logic [CNT_W-1:0] phase_count,
  output logic             err_conflict,
  output logic             err_dark,
  output logic             err_short,
  output logic             err_stuck,
  output logic             err_any
`ifdef MON_DWELL_STATS_EN
  ,
  output logic [CNT_W-1:0] last_dwell,
  output logic [CNT_W-1:0] peak_dwell
`endif
);

  localparam logic [CNT_W-1:0] RMIN = CNT_W'(RED_MIN);
  localparam logic [CNT_W-1:0] RMAX = CNT_W'(RED_MAX);
  localparam logic [CNT_W-1:0] GMIN = CNT_W'(GRN_MIN);
  localparam logic [CNT_W-1:0] GMAX = CNT_W'(GRN_MAX);

  state_e           state, nxt;
  logic [CNT_W-1:0] dwell, cur_min, cur_max;
  logic [1:0]       lamps, own, other;
  logic             d_clr, d_load, d_inc, step;
  logic             s_conf, s_dark, s_short, s_stuck;

  assign lamps   = {red, green};
  assign cur_min = (state == IN_RED) ? RMIN : GMIN;
  assign cur_max = (state == IN_RED) ? RMAX : GMAX;
  assign own     = (state == IN_RED) ? LAMP_RED : LAMP_GREEN;
  assign other   = (state == IN_RED) ? LAMP_GREEN : LAMP_RED;

  always_comb begin
    nxt     = state;
    d_clr   = 1'b0;
    d_load  = 1'b0;
    d_inc   = 1'b0;
    step    = 1'b0;
    s_conf  = 1'b0;
    s_dark  = 1'b0;
    s_short = 1'b0;
    s_stuck = 1'b0;
    case (state)
      SYNC: begin
        // dark before the controller starts is legal, so 00 is ignored here
        case (lamps)
          LAMP_RED:   begin nxt = IN_RED;   d_load = 1'b1; end
          LAMP_GREEN: begin nxt = IN_GREEN; d_load = 1'b1; end
          LAMP_BOTH:  s_conf = 1'b1;
          default: ;
        endcase
      end
      IN_RED, IN_GREEN: begin
        if (lamps == own) begin
          d_inc   = 1'b1;
          s_stuck = (dwell == cur_max);
        end else if (lamps == other) begin
          s_short = (dwell < cur_min);
          nxt     = (state == IN_RED) ? IN_GREEN : IN_RED;
          d_load  = 1'b1;
          step    = 1'b1;
        end else begin
          s_conf = (lamps == LAMP_BOTH);
          s_dark = (lamps == LAMP_DARK);
          nxt    = SYNC;
          d_clr  = 1'b1;
        end
      end
      default: begin
        nxt   = SYNC;
        d_clr = 1'b1;
      end
    endcase
  end

  dwell_counter #(.CNT_W(CNT_W)) u_dwell (
    .clk   (clk),
    .reset (reset),
    .clr   (d_clr),
    .load1 (d_load),
    .inc   (d_inc),
    .count (dwell)
  );

  // a new error in the clearing cycle survives; the rest clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= SYNC;
      phase        <= PH_UNKNOWN;
      synced       <= 1'b0;
      phase_count  <= '0;
      err_conflict <= 1'b0;
      err_dark     <= 1'b0;
      err_short    <= 1'b0;
      err_stuck    <= 1'b0;
    end else begin
      state        <= nxt;
      phase        <= phase_of(nxt);
      synced       <= (nxt != SYNC);
      if (step) phase_count <= phase_count + CNT_W'(1);
      err_conflict <= s_conf  | (err_conflict & ~clr_err);
      err_dark     <= s_dark  | (err_dark     & ~clr_err);
      err_short    <= s_short | (err_short    & ~clr_err);
      err_stuck    <= s_stuck | (err_stuck    & ~clr_err);
    end
  end

  assign err_any = err_conflict | err_dark | err_short | err_stuck;

`ifdef MON_DWELL_STATS_EN
  logic [CNT_W-1:0] dwell_nxt, peak_base;

  // mirror the counter's next value so peak tracks without an extra cycle
  always_comb begin
    dwell_nxt = dwell;
    if (d_clr)                        dwell_nxt = '0;
    else if (d_load)                  dwell_nxt = CNT_W'(1);
    else if (d_inc && dwell != '1)    dwell_nxt = dwell + CNT_W'(1);
    peak_base = clr_err ? '0 : peak_dwell;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_dwell <= '0;
      peak_dwell <= '0;
    end else begin
      if (step) last_dwell <= dwell;
      peak_dwell <= (dwell_nxt > peak_base) ? dwell_nxt : peak_base;
    end
  end
`endif

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Randomized + directed bench for traffic_light_monitor; two instances with different limits.
module tb_traffic_light_monitor;

  logic clk = 1'b0;
  logic reset, red, green, clr_err;

  logic [1:0] phase0, phase1;
  logic       synced0, synced1;
  logic [7:0] pc0;
  logic [2:0] pc1;
  logic       ec0, ed0, es0, est0, ea0;
  logic       ec1, ed1, es1, est1, ea1;
`ifdef MON_DWELL_STATS_EN
  logic [7:0] last0, peak0;
  logic [2:0] last1, peak1;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // per-instance limits: {CNT_W, RED_MIN, RED_MAX, GRN_MIN, GRN_MAX}
  int pw[2]    = '{8, 3};
  int prmin[2] = '{1, 2};
  int prmax[2] = '{2, 3};
  int pgmin[2] = '{1, 2};
  int pgmax[2] = '{1, 6};

  // model: current lit phase (0 none, 1 red, 2 green), length of its run, completed phases
  int mph[2], mrun[2], mcnt[2];
  bit mconf[2], mdark[2], mshort[2], mstuck[2];
  int mlast[2], mpeak[2];

  always #5 clk = ~clk;

  traffic_light_monitor u_dut0 (
    .clk(clk), .reset(reset), .red(red), .green(green), .clr_err(clr_err),
    .phase(phase0), .synced(synced0), .phase_count(pc0),
    .err_conflict(ec0), .err_dark(ed0), .err_short(es0), .err_stuck(est0), .err_any(ea0)
`ifdef MON_DWELL_STATS_EN
    , .last_dwell(last0), .peak_dwell(peak0)
`endif
  );

  traffic_light_monitor #(.CNT_W(3), .RED_MIN(2), .RED_MAX(3), .GRN_MIN(2), .GRN_MAX(6)) u_dut1 (
    .clk(clk), .reset(reset), .red(red), .green(green), .clr_err(clr_err),
    .phase(phase1), .synced(synced1), .phase_count(pc1),
    .err_conflict(ec1), .err_dark(ed1), .err_short(es1), .err_stuck(est1), .err_any(ea1)
`ifdef MON_DWELL_STATS_EN
    , .last_dwell(last1), .peak_dwell(peak1)
`endif
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mph[i] = 0; mrun[i] = 0; mcnt[i] = 0;
      mconf[i] = 0; mdark[i] = 0; mshort[i] = 0; mstuck[i] = 0;
      mlast[i] = 0; mpeak[i] = 0;
    end
  endtask

  task automatic model_step(input int i, input logic [1:0] s, input logic c);
    bit nc = 0, nd = 0, ns = 0, nst = 0;
    int sat = (1 << pw[i]) - 1;
    int mn  = (mph[i] == 1) ? prmin[i] : pgmin[i];
    int mx  = (mph[i] == 1) ? prmax[i] : pgmax[i];
    int own = (mph[i] == 1) ? 2 : 1;
    int oth = 3 - own;
    if (mph[i] == 0) begin
      if (s == 2'b10)      begin mph[i] = 1; mrun[i] = 1; end
      else if (s == 2'b01) begin mph[i] = 2; mrun[i] = 1; end
      else if (s == 2'b11) nc = 1;
    end else if (int'(s) == own) begin
      if (mrun[i] == mx) nst = 1;
      if (mrun[i] < sat) mrun[i]++;
    end else if (int'(s) == oth) begin
      if (mrun[i] < mn) ns = 1;
      mlast[i] = mrun[i];
      mph[i]   = 3 - mph[i];
      mrun[i]  = 1;
      mcnt[i]  = (mcnt[i] + 1) % (sat + 1);
    end else begin
      if (s == 2'b11) nc = 1; else nd = 1;
      mph[i] = 0; mrun[i] = 0;
    end
    mconf[i]  = nc  | (mconf[i]  & !c);
    mdark[i]  = nd  | (mdark[i]  & !c);
    mshort[i] = ns  | (mshort[i] & !c);
    mstuck[i] = nst | (mstuck[i] & !c);
    if (c) mpeak[i] = 0;
    if (mrun[i] > mpeak[i]) mpeak[i] = mrun[i];
  endtask

  task automatic cmp_inst(input int i);
    logic [31:0] ph, sy, pc, ec, ed, es, est, ea;
    if (i == 0) begin
      ph = 32'(phase0); sy = 32'(synced0); pc = 32'(pc0); ec = 32'(ec0);
      ed = 32'(ed0); es = 32'(es0); est = 32'(est0); ea = 32'(ea0);
    end else begin
      ph = 32'(phase1); sy = 32'(synced1); pc = 32'(pc1); ec = 32'(ec1);
      ed = 32'(ed1); es = 32'(es1); est = 32'(est1); ea = 32'(ea1);
    end
    chk($sformatf("dut%0d phase", i), ph, mph[i]);
    chk($sformatf("dut%0d synced", i), sy, 32'(mph[i] != 0));
    chk($sformatf("dut%0d phase_count", i), pc, mcnt[i]);
    chk($sformatf("dut%0d err_conflict", i), ec, 32'(mconf[i]));
    chk($sformatf("dut%0d err_dark", i), ed, 32'(mdark[i]));
    chk($sformatf("dut%0d err_short", i), es, 32'(mshort[i]));
    chk($sformatf("dut%0d err_stuck", i), est, 32'(mstuck[i]));
    chk($sformatf("dut%0d err_any", i), ea,
        32'(mconf[i] | mdark[i] | mshort[i] | mstuck[i]));
`ifdef MON_DWELL_STATS_EN
    chk($sformatf("dut%0d last_dwell", i), (i == 0) ? 32'(last0) : 32'(last1), mlast[i]);
    chk($sformatf("dut%0d peak_dwell", i), (i == 0) ? 32'(peak0) : 32'(peak1), mpeak[i]);
`endif
  endtask

  task automatic cmp_all();
    cmp_inst(0);
    cmp_inst(1);
  endtask

  // single compare process: advance the model on each sampled edge, then check
  always @(posedge clk) begin
    if (!reset) begin
      model_step(0, {red, green}, clr_err);
      model_step(1, {red, green}, clr_err);
      #1 cmp_all();
    end
  end

  always @(posedge reset) model_reset();

  task automatic drive(input logic [1:0] s, input logic c);
    @(negedge clk);
    {red, green} = s;
    clr_err = c;
    @(posedge clk);
    #2;
  endtask

  task automatic rst_pulse();
    @(negedge clk);
    #2 reset = 1'b1;
    #1 cmp_all();
    chk("async reset phase", 32'(phase0), 0);
    chk("async reset err_any", 32'(ea0), 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  localparam logic [1:0] R = 2'b10, G = 2'b01, D = 2'b00, B = 2'b11;

  initial begin
    logic [1:0] seq1 [8];
    logic [1:0] last_legal;
    seq1 = '{R, G, R, R, G, R, R, G};
    reset = 1'b1; red = 1'b0; green = 1'b0; clr_err = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    cmp_all();
    chk("reset synced", 32'(synced0), 0);
    chk("reset phase_count", 32'(pc0), 0);
    reset = 1'b0;

    // legal alternation
    for (int k = 0; k < 8; k++) begin
      drive(seq1[k], 1'b0);
      if (k == 0) chk("t1 synced after first sample", 32'(synced0), 1);
      chk("t1 err_any stays 0", 32'(ea0), 0);
    end
    chk("t1 phase_count", 32'(pc0), 5);

    // conflict while synced, then clear
    drive(R, 1'b0);
    drive(B, 1'b0);
    chk("t2 err_conflict", 32'(ec0), 1);
    chk("t2 phase", 32'(phase0), 0);
    chk("t2 synced", 32'(synced0), 0);
    drive(D, 1'b1);
    chk("t2 cleared", 32'(ec0), 0);

    // stuck green, set only once; short red on the stricter instance
    drive(G, 1'b0);
    drive(G, 1'b0);
    chk("t3 err_stuck", 32'(est0), 1);
    drive(G, 1'b1);
    chk("t3 stuck not re-set", 32'(est0), 0);
    drive(R, 1'b0);
    drive(G, 1'b0);
    chk("t3 err_short strict", 32'(es1), 1);
    chk("t3 no short default", 32'(es0), 0);

    // dark while synced; dark in SYNC is silent
    drive(D, 1'b0);
    chk("t4 err_dark", 32'(ed0), 1);
    chk("t4 synced", 32'(synced0), 0);
    drive(D, 1'b1);
    drive(D, 1'b0);
    chk("t4 dark not re-set", 32'(ed0), 0);
    chk("t4 err_any", 32'(ea0), 0);

    // async reset mid-green with stuck set, then clr + conflict collision
    drive(G, 1'b0);
    drive(G, 1'b0);
    chk("t5 stuck before reset", 32'(est0), 1);
    rst_pulse();
    drive(R, 1'b0);
    drive(R, 1'b0);
    drive(R, 1'b0);
    chk("t5 stuck red", 32'(est0), 1);
    drive(B, 1'b1);
    chk("t5 new conflict wins", 32'(ec0), 1);
    chk("t5 stuck cleared", 32'(est0), 0);

`ifdef MON_DWELL_STATS_EN
    rst_pulse();
    drive(R, 1'b0); drive(R, 1'b0); drive(G, 1'b0); drive(R, 1'b0);
    chk("t6 last_dwell", 32'(last0), 1);
    chk("t6 peak_dwell", 32'(peak0), 2);
`endif

    // long hold saturates the 3-bit instance's dwell
    rst_pulse();
    repeat (12) drive(R, 1'b0);
    drive(G, 1'b0);
    chk("sat no short", 32'(es1), 0);

    // randomized traffic with occasional faults, clears and resets
    last_legal = G;
    for (int n = 0; n < 3000; n++) begin
      int pick;
      logic [1:0] s;
      pick = $urandom_range(0, 99);
      if (pick < 3)       s = B;
      else if (pick < 6)  s = D;
      else if (pick < 40) s = (last_legal == R) ? G : R;
      else                s = last_legal;
      if (s == R || s == G) last_legal = s;
      if ($urandom_range(0, 399) == 0) rst_pulse();
      drive(s, ($urandom_range(0, 24) == 0));
    end

    drive(D, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
